uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter (8N1/8N2 style framing)
// Words queue in a DEPTH-entry FIFO and are serialised back-to-back, LSB first.
module uart_tx_fifo #(
  parameter int N     = 8,
  parameter int STOP  = 0,
  parameter int DIV   = 434,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     wr,
  input  logic [N-1:0]             data,
  output logic                     q,
  output logic                     ready,
  output logic                     empty,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOPB} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [BW-1:0] bitn, bitn_d;
  logic [N-1:0]  sh, sh_d;
  logic          q_d;
  logic          bit_end;
  logic          push, pop;
  logic [AW:0]   level_d;
  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  assign bit_end = (cnt == CW'(DIV - 1));

  always_comb begin
    push    = wr && ready;
    pop     = 1'b0;
    state_d = state;
    cnt_d   = bit_end ? '0 : cnt + CW'(1);
    bitn_d  = bitn;
    sh_d    = sh;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          bitn_d  = '0;
          sh_d    = mem[rptr];
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        sh_d = sh >> 1;
        if (bitn == BW'(N - 1)) begin
          state_d = STOPB;
          bitn_d  = '0;
        end else begin
          bitn_d = bitn + BW'(1);
        end
      end
      STOPB: if (bit_end) begin
        // Back-to-back frames: pop the next word on the final stop-bit edge.
        if (bitn == BW'(STOP)) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = START;
            bitn_d  = '0;
            sh_d    = mem[rptr];
          end else begin
            state_d = IDLE;
          end
        end else begin
          bitn_d = bitn + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    level_d = level + (AW+1)'(push) - (AW+1)'(pop);
    case (state_d)
      START:   q_d = 1'b0;
      DATA:    q_d = sh_d[0];
      default: q_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      sh    <= '0;
      q     <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      bitn  <= bitn_d;
      sh    <= sh_d;
      q     <= q_d;
      busy  <= (state_d != IDLE);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ready <= 1'b1;
      empty <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      level <= level_d;
      ready <= (level_d != (AW+1)'(DEPTH));
      empty <= (level_d == '0);
      if (wr && !ready) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data;
  end

endmodule
